// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
// Drives one narrow combinational adder word-by-word (LSW first) to add or
// subtract operands WORDS times wider. The carry between words is held in a
// register. A requester talks to it through a start/done handshake.
//
// Handshake: start is looked at only in IDLE. When it is accepted, op_a, op_b
// and sub are captured on the same edge. Later starts are ignored while busy.
// done pulses for exactly one cycle. result/cf/of stay valid from that cycle
// until the next start is accepted.
module multiword_add_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        sub,
  input  logic [DATA_WIDTH*WORDS-1:0] op_a,
  input  logic [DATA_WIDTH*WORDS-1:0] op_b,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_WIDTH*WORDS-1:0] result,
  output logic                        cf,
  output logic                        of,
  output logic [DATA_WIDTH-1:0]       add_a,
  output logic [DATA_WIDTH-1:0]       add_b,
  output logic                        add_cin,
  input  logic [DATA_WIDTH-1:0]       add_s,
  input  logic                        add_cf,
  input  logic                        add_of,
  output logic [1:0]                  dbg_state
);

  localparam int W     = DATA_WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;

  // Next-state logic and the adder port drive. The adder is idle (all zero)
  // outside RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cf_d     = cf_q;
    of_d     = of_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          sub_d    = sub;
          idx_d    = '0;
          // For subtraction the carry-in is 1, so with B inverted
          // we get A + ~B + 1.
          carry_d  = sub;
          result_d = '0;
          cf_d     = 1'b0;
          of_d     = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
        add_b   = b_q[idx_q*DATA_WIDTH +: DATA_WIDTH] ^ {DATA_WIDTH{sub_q}};
        add_cin = carry_q;
        result_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = add_s;
        carry_d = add_cf;
        if (idx_q == LAST_IDX) begin
          // A subtraction reports borrow, which is the inverse of carry-out.
          cf_d    = add_cf ^ sub_q;
          of_d    = add_of;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. A reset here throws away any operation that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign cf        = cf_q;
  assign of        = of_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Testbench for multiword_add_sequencer with DATA_WIDTH=8 and WORDS=4.
// The 8-bit ripple adder is modelled behaviourally in this bench.
module tb_multiword_add_sequencer;

  localparam int DW = 8;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sub;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          cf;
  logic          of;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic          add_cin;
  logic [DW-1:0] add_s;
  logic          add_cf;
  logic          add_of;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  multiword_add_sequencer #(.DATA_WIDTH(DW), .WORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .cf(cf), .of(of),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cf(add_cf), .add_of(add_of), .dbg_state(dbg_state)
  );

  // Behavioural 8-bit adder: sum, carry-out and signed overflow
  logic [DW:0] sum9;
  assign sum9   = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_cin};
  assign add_s  = sum9[DW-1:0];
  assign add_cf = sum9[DW];
  assign add_of = (add_a[DW-1] == add_b[DW-1]) && (add_s[DW-1] != add_a[DW-1]);

  // Clock and reset generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one operation (the caller is at a negedge in IDLE), checks the
  // latency and the outputs, and returns at the negedge of the following IDLE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] er, input logic ecf,
                        input logic eof);
    int lat;
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; sub = $urandom_range(0, 1);
    @(negedge clk);
    lat = 1;
    check({tag, "_clr"}, {32'd0, result}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_res"}, {32'd0, result}, {32'd0, er});
    check({tag, "_cf"}, {63'd0, cf}, {63'd0, ecf});
    check({tag, "_of"}, {63'd0, of}, {63'd0, eof});
    @(negedge clk);
    check({tag, "_post"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb, rr;
    logic rs, rc, ro;
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_res", {32'd0, result}, 64'd0);
    check("rst_flags", {62'd0, cf, of}, 64'd0);
    check("rst_add", {47'd0, add_a, add_b, add_cin}, 64'd0);
    rst = 1'b0;

    // Directed arithmetic vectors
    run_op("add_carry", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("add_ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_borrow", 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
    run_op("sub_zero", 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b0);

    // Handshake: start stays high while the unit is busy
    start = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222; sub = 1'b0;
    @(posedge clk); #1;
    op_a = 32'h00000001; op_b = 32'h00000002;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hs_lat1", 64'(lat), 64'd5);
    check("hs_res1", {32'd0, result}, 64'h33333333);
    @(negedge clk);
    check("hs_idle", {62'd0, done, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("hs_run2", {63'd0, busy}, 64'd1);
    check("hs_clr2", {32'd0, result}, 64'd0);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hs_lat2", 64'(lat), 64'd5);
    check("hs_res2", {32'd0, result}, 64'h3);
    @(negedge clk);

    // Reset in the second RUN cycle
    start = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", {63'd0, busy}, 64'd0);
    check("mid_done", {63'd0, done}, 64'd0);
    check("mid_res", {32'd0, result}, 64'd0);
    check("mid_add", {47'd0, add_a, add_b, add_cin}, 64'd0);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) lat++;
    end
    check("mid_nodone", 64'(lat), 64'd0);
    run_op("post_rst", 32'h01010101, 32'h01010101, 1'b0, 32'h02020202, 1'b0, 1'b0);

    // Random operations issued back to back against reference arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (!rs) begin
        {rc, rr} = {1'b0, ra} + {1'b0, rb};
        ro = (ra[W-1] == rb[W-1]) && (rr[W-1] != ra[W-1]);
      end else begin
        rr = ra - rb;
        rc = (ra < rb);
        ro = (ra[W-1] != rb[W-1]) && (rr[W-1] != ra[W-1]);
      end
      run_op("rnd", ra, rb, rs, rr, rc, ro);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequences a narrow combinational DATA_WIDTH adder (ripple-carry or carry-lookahead, same A/B/Cin/S/CF/OF port set) to add or subtract operands WORDS times wider. One word per cycle, least significant first, with carry chained through a register. Sits between a requester using a start/done handshake and a single shared adder instance. Trades latency for area on wide arithmetic.

## Interface
- DATA_WIDTH, 8, width of one adder word
- WORDS, 4, number of words per operand (≥ 2); operand width W = DATA_WIDTH*WORDS
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A−B; sampled with start
- op_a  in  W  operand A; sampled with start
- op_b  in  W  operand B; sampled with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, result valid
- result  out  W  sum/difference, held until next accepted start
- cf  out  1  add: carry-out of MSW; sub: borrow (= ~carry-out of MSW)
- of  out  1  signed overflow of full-width operation
- add_a  out  DATA_WIDTH  to adder A
- add_b  out  DATA_WIDTH  to adder B
- add_cin  out  1  to adder Cin
- add_s  in  DATA_WIDTH  from adder S
- add_cf  in  1  from adder CF
- add_of  in  1  from adder OF

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture op_a, op_b, sub; idx←0; carry←sub; clear result, cf, of; go RUN. start=0 → stay.
- RUN, word idx: add_a = a_reg[idx], add_b = b_reg[idx] XOR {DATA_WIDTH{sub_reg}}, add_cin = carry. At edge: result[idx]←add_s, carry←add_cf, idx←idx+1.
- RUN, idx = WORDS−1: additionally cf←add_cf XOR sub_reg, of←add_of; go DONE.
- DONE: done=1 for one cycle; go IDLE.
- Outside RUN: add_a, add_b, add_cin driven 0.
- start while busy: ignored, no effect on any state. start in DONE cycle: ignored.
- Arithmetic is modulo 2^W; idx width ceil(log2(WORDS)), never wraps past WORDS−1.
- The adder is purely combinational. The path from add_* outputs to add_s/add_cf/add_of closes within one cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, cf 0, of 0, add_a/add_b/add_cin 0, internal regs 0.
- rst in any state, including mid-RUN, aborts in the same edge. The partial result is discarded (result 0). rst has priority over start.
- start accepted at edge T. RUN occupies cycles T+1 … T+WORDS. done=1 and busy=1 in cycle T+WORDS+1. busy=0 from T+WORDS+2.
- Latency start→done = WORDS+1 cycles. Throughput one operation per WORDS+2 cycles.
- result, cf and of are stable from cycle T+WORDS+1 until the next accepted start clears them.
- Earliest next accepted start: the edge ending cycle T+WORDS+2 (first IDLE cycle).

## Test plan
DUT: DATA_WIDTH=8, WORDS=4, with a ripple_carry_adder #(8) as the adder.
- Add with inter-word carry: 0x000000FF + 0x00000001 → result 0x00000100, cf 0, of 0. done exactly 5 cycles after the start edge, a single-cycle pulse.
- Full carry ripple: 0xFFFFFFFF + 0x00000001 → result 0x00000000, cf 1, of 0. 0x7FFFFFFF + 0x00000001 → 0x80000000, cf 0, of 1.
- Subtract: 0x00000000 − 0x00000001 → 0xFFFFFFFF, cf (borrow) 1, of 0. 0x80000000 − 0x00000001 → 0x7FFFFFFF, cf 0, of 1. 0x12345678 − 0x12345678 → 0, cf 0, of 0.
- Handshake: hold start high continuously with new operands 0x1+0x2 during busy. The in-flight result is unaffected. The next operation starts only in the first IDLE cycle. busy drops exactly one cycle after done.
- Reset mid-operation: assert rst during the 2nd RUN cycle → next cycle busy 0, done 0, result 0, add_* 0, and no done pulse follows. A subsequent start of 0x01010101 + 0x01010101 → 0x02020202.
- Random: 1000 random op_a/op_b/sub triples checked against 32-bit reference arithmetic for result, cf and of, with back-to-back starts.
